div_restore: RTL and testbench

Iterative restoring divider for the arithmetic datapath, with valid/ready handshakes on both sides.
- Produces quotient and remainder one bit per cycle by repeated trial subtraction, the inverse operation of the add_sub adder.
- Sits beside alu as a multi-cycle functional unit.
- Operands arrive on an input handshake; results leave on an output handshake with backpressure.

---
 rtl/div_restore.sv | 151 +++++++++++++++
 tb/tb_div_restore.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_restore.sv
// Iterative restoring divider with valid/ready on both sides: one quotient bit per cycle.
// Optional signed mode is compiled in with DIV_SIGNED_EN (adds sign_op and a sign-fix cycle).
module div_restore #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
`ifdef DIV_SIGNED_EN
  input  logic             sign_op,
`endif
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for operands (in_ready once out of reset)
  // CALC  | one trial subtraction per cycle, counter counts down from WIDTH
  // FIX   | signed mode only: negate quotient/remainder magnitudes as needed
  // DONE  | result presented, held until out_ready
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2, FIX = 2'd3} state_t;

  state_t           state, state_nxt;
  logic             rdy_q;
  logic [WIDTH-1:0] q_reg, rem_reg, dvs_reg;
  logic [CNT_W-1:0] cnt;
  logic             dbz_reg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted, trial;
  logic             accept;
  state_t           calc_exit;

`ifdef DIV_SIGNED_EN
  logic sgn, q_neg, r_neg;

  always_comb begin
    dvd_mag   = (sign_op && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_mag   = (sign_op && divisor[WIDTH-1])  ? -divisor  : divisor;
    calc_exit = sgn ? FIX : DONE;
  end
`else
  always_comb begin
    dvd_mag   = dividend;
    dvs_mag   = divisor;
    calc_exit = DONE;
  end
`endif

  // Partial remainder is always below the divisor, so WIDTH+1 bits hold the shifted value.
  assign shifted = {rem_reg, q_reg[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_reg};
  assign accept  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rdy_q;
        if (in_valid && rdy_q) state_nxt = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = calc_exit;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q   <= 1'b0;
      q_reg   <= '0;
      rem_reg <= '0;
      dvs_reg <= '0;
      cnt     <= '0;
      dbz_reg <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn     <= 1'b0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
`endif
    end else begin
      rdy_q <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            dvs_reg <= dvs_mag;
`ifdef DIV_SIGNED_EN
            sgn   <= sign_op;
            q_neg <= sign_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg <= sign_op && dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
              q_reg   <= '1;
              rem_reg <= dividend;
              cnt     <= '0;
              dbz_reg <= 1'b1;
            end else begin
              q_reg   <= dvd_mag;
              rem_reg <= '0;
              cnt     <= CNT_W'(WIDTH);
              dbz_reg <= 1'b0;
            end
          end
        end
        CALC: begin
          cnt     <= cnt - CNT_W'(1);
          q_reg   <= {q_reg[WIDTH-2:0], ~trial[WIDTH]};
          rem_reg <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        end
`ifdef DIV_SIGNED_EN
        FIX: begin
          if (q_neg) q_reg   <= -q_reg;
          if (r_neg) rem_reg <= -rem_reg;
        end
`endif
        default: ;
      endcase
    end
  end

  assign quotient    = q_reg;
  assign remainder   = rem_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div_restore.sv
// Self-checking bench for div_restore (WIDTH=32): scoreboard of expected results checked on output.
// Signed cases are included when DIV_SIGNED_EN is defined.
module tb_div_restore;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend, divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient, remainder;
  logic        div_by_zero;
  logic        busy;
`ifdef DIV_SIGNED_EN
  logic        sign_op;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   acc_log[$];
  int   hs_log[$];

  div_restore #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
`ifdef DIV_SIGNED_EN
    .sign_op    (sign_op),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sop);
    exp_t e;
    logic signed [31:0] sa, sd;
    e.acc = 0;
    e.dbz = 1'b0;
    e.lat = sop ? 34 : 33;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1; e.lat = 1;
    end else if (!sop) begin
      e.q = a / b; e.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = a; e.r = 32'd0;
    end else begin
      sa = a; sd = b;
      e.q = sa / sd; e.r = sa % sd;
    end
    return e;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sop);
    int n = 0;
    exp_t e;
    dividend = a;
    divisor  = b;
`ifdef DIV_SIGNED_EN
    sign_op  = sop;
`endif
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_timeout in_ready=%b required=1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = model(a, b, sop);
    e.acc = cyc;
    sb.push_back(e);
    acc_log.push_back(cyc);
  endtask

  task automatic recv(input int hold);
    int n = 0;
    exp_t e;
    while (!out_valid && n < 300) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL recv_timeout out_valid=%b required=1", out_valid);
      return;
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL unexpected_result got q=%h r=%h required none", quotient, remainder);
      return;
    end
    e = sb.pop_front();
    total++;
    if (cyc - e.acc + 1 !== e.lat) begin
      bad++;
      $display("FAIL latency got=%0d required=%0d", cyc - e.acc + 1, e.lat);
    end
    total++;
    if (quotient !== e.q) begin
      bad++;
      $display("FAIL quotient got=%h required=%h", quotient, e.q);
    end
    total++;
    if (remainder !== e.r) begin
      bad++;
      $display("FAIL remainder got=%h required=%h", remainder, e.r);
    end
    total++;
    if (div_by_zero !== e.dbz || busy !== 1'b1) begin
      bad++;
      $display("FAIL flags got dbz=%b busy=%b required dbz=%b busy=1", div_by_zero, busy, e.dbz);
    end
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        in_valid = i[0];
        dividend = $urandom;
        divisor  = $urandom;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== e.q ||
            remainder !== e.r || div_by_zero !== e.dbz) begin
          bad++;
          $display("FAIL hold_%0d got v=%b rdy=%b q=%h r=%h required v=1 rdy=0 q=%h r=%h",
                   i, out_valid, in_ready, quotient, remainder, e.q, e.r);
        end
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    hs_log.push_back(cyc);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_handshake got v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got rdy=%b v=%b busy=%b dbz=%b required all 0",
               in_ready, out_valid, busy, div_by_zero);
    end
    total++;
    if (quotient !== 32'd0 || remainder !== 32'd0) begin
      bad++;
      $display("FAIL reset_data got q=%h r=%h required 0 0", quotient, remainder);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_at_release got=%b required=0", in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_release got=%b required=1", in_ready);
    end
  endtask

  task automatic test_basic();
    send(32'd100, 32'd7, 1'b0);
    recv(0);
  endtask

  task automatic test_div_zero();
    send(32'd5, 32'd0, 1'b0);
    recv(0);
  endtask

  task automatic test_back_to_back();
    int a0 = acc_log.size();
    int h0 = hs_log.size();
    fork
      begin
        send(32'hFFFF_FFFF, 32'd1, 1'b0);
        send(32'd3, 32'd9, 1'b0);
      end
      begin
        recv(0);
        recv(0);
      end
    join
    total++;
    if (acc_log.size() < a0 + 2 || hs_log.size() < h0 + 1 || acc_log[a0 + 1] != hs_log[h0] + 1) begin
      bad++;
      $display("FAIL b2b_accept_timing got acc=%0d required hs+1=%0d",
               (acc_log.size() >= a0 + 2) ? acc_log[a0 + 1] : -1,
               (hs_log.size() >= h0 + 1) ? hs_log[h0] + 1 : -1);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(32'd1000, 32'd10, 1'b0);
    recv(10);
  endtask

  task automatic test_reset_abort();
    exp_t dropped;
    send(32'd1000, 32'd3, 1'b0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 ||
        quotient !== 32'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL abort_reset got v=%b busy=%b rdy=%b q=%h r=%h dbz=%b required all 0",
               out_valid, busy, in_ready, quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    if (sb.size() > 0) dropped = sb.pop_back();
    send(32'd7, 32'd7, 1'b0);
    recv(0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = i[0] ? 32'($urandom_range(1, 20)) : ($urandom >> $urandom_range(0, 31));
      send(a, b, 1'b0);
      recv(0);
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    send(-32'sd7, 32'd2, 1'b1);          recv(0);
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); recv(0);
    send(32'd100, -32'sd7, 1'b1);        recv(0);
    send(-32'sd5, 32'd0, 1'b1);          recv(0);
    send(32'd100, 32'd7, 1'b0);          recv(0);
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = 32'd0;
    divisor   = 32'd0;
`ifdef DIV_SIGNED_EN
    sign_op   = 1'b0;
`endif
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_backpressure();
    test_reset_abort();
    test_random();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover_expected got=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
